// File: rtl/uart_tx_if.sv
// Handshake and serial-line signals of the UART transmitter.
// The master drives the byte request and the slave (the engine) drives the line and status flags.
interface uart_tx_if;
  logic       send;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] baud_rate;
  logic       data_tx;
  logic       active_flag;
  logic       done_flag;

  modport master (
    output send, data_in, parity_type, baud_rate,
    input  data_tx, active_flag, done_flag
  );

  modport slave (
    input  send, data_in, parity_type, baud_rate,
    output data_tx, active_flag, done_flag
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte per request as an 11-bit frame
// (start, D0..D7 LSB first, parity slot, stop) with a per-frame baud divider.
module uart_tx_engine #(
  parameter int CLK_FREQ = 50_000_000
) (
  input logic      clock,
  input logic      reset_n,
  uart_tx_if.slave bus
);

  localparam int DIV0  = CLK_FREQ / 2400;
  localparam int DIV1  = CLK_FREQ / 4800;
  localparam int DIV2  = CLK_FREQ / 9600;
  localparam int DIV3  = CLK_FREQ / 19200;
  // Counter only ever reaches DIV-1, so the 2400 divisor sets the width.
  localparam int CNT_W = $clog2(DIV0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [1:0]       baud_q, baud_d;
  logic             data_tx_q, data_tx_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] div_m1;
  logic             last;

  // Terminal count of the bit-period counter for the latched baud rate.
  always_comb begin
    case (baud_q)
      2'b00:   div_m1 = CNT_W'(DIV0 - 1);
      2'b01:   div_m1 = CNT_W'(DIV1 - 1);
      2'b10:   div_m1 = CNT_W'(DIV2 - 1);
      default: div_m1 = CNT_W'(DIV3 - 1);
    endcase
  end

  assign last = (cnt_q == div_m1);

  // Next-state logic; the line value is registered alongside the state so it
  // changes on the same edge the FSM moves between bit periods.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    baud_d    = baud_q;
    data_tx_d = data_tx_q;
    active_d  = active_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        data_tx_d = 1'b1;
        active_d  = 1'b0;
        // The done cycle is itself an IDLE cycle, so a request here starts
        // the next frame on the following clock.
        if (bus.send) begin
          shift_d = bus.data_in;
          baud_d  = bus.baud_rate;
          case (bus.parity_type)
            2'b01:   par_d = ~^bus.data_in;
            2'b10:   par_d = ^bus.data_in;
            default: par_d = 1'b1;
          endcase
          state_d   = S_START;
          data_tx_d = 1'b0;
          active_d  = 1'b1;
        end
      end

      S_START: begin
        if (last) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_DATA;
          data_tx_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            state_d   = S_PARITY;
            data_tx_d = par_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            data_tx_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (last) begin
          cnt_d     = '0;
          state_d   = S_STOP;
          data_tx_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (last) begin
          cnt_d     = '0;
          state_d   = S_IDLE;
          data_tx_d = 1'b1;
          active_d  = 1'b0;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        data_tx_d = 1'b1;
        active_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset forces the line high at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      baud_q    <= '0;
      data_tx_q <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      baud_q    <= baud_d;
      data_tx_q <= data_tx_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign bus.data_tx     = data_tx_q;
  assign bus.active_flag = active_q;
  assign bus.done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine at CLK_FREQ=96000 (divisors 40/20/10/5).
// Expected line waveforms come from a frame model built from the byte,
// parity mode and baud rate; outputs are sampled on the falling edge.
module tb_uart_tx_engine;
  localparam int CLK_FREQ = 96000;

  logic clock = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   done_cyc;
  int   prev_done;

  uart_tx_if bus ();

  uart_tx_engine #(.CLK_FREQ(CLK_FREQ)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Free-running cycle count used to measure done-pulse spacing.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_div(input logic [1:0] b);
    int baud;
    baud = 2400 << b;
    return CLK_FREQ / baud;
  endfunction

  // Frame bit k of the 11-bit frame as it should appear on the line.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic [1:0] p);
    logic [10:0] f;
    int ones;
    logic pb;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    if (p == 2'b01)      pb = (ones % 2 == 0);   // odd: total ones odd
    else if (p == 2'b10) pb = (ones % 2 == 1);   // even: total ones even
    else                 pb = 1'b1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = pb;
    f[10] = 1'b1;
    return f;
  endfunction

  // Called just after the accept edge. Checks every cycle of the frame and
  // the done cycle. keep/nd set send and data_in right after accept; mid
  // perturbs all inputs at clock 25 of the frame.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b,
                           input bit mid, input bit keep, input logic [7:0] nd);
    logic [10:0] fr;
    int div;
    div = ref_div(b);
    fr  = ref_frame(d, p);
    for (int k = 0; k < 11 * div; k++) begin
      @(negedge clock);
      if (k == 0) begin
        bus.send    = keep;
        bus.data_in = nd;
      end
      if (mid && k == 25) begin
        bus.send        = 1'b1;
        bus.data_in     = ~d;
        bus.parity_type = ~p;
        bus.baud_rate   = ~b;
      end
      if (mid && k == 26) bus.send = 1'b0;
      chk("line", 32'(bus.data_tx), 32'(fr[k/div]));
      chk("active", 32'(bus.active_flag), 32'd1);
      chk("done_early", 32'(bus.done_flag), 32'd0);
    end
    @(negedge clock);
    chk("done_pulse", 32'(bus.done_flag), 32'd1);
    chk("done_active", 32'(bus.active_flag), 32'd0);
    chk("done_line", 32'(bus.data_tx), 32'd1);
    done_cyc = cyc;
  endtask

  // Issue a single-cycle request and check the resulting frame.
  task automatic send_one(input logic [7:0] d, input logic [1:0] p, input logic [1:0] b, input bit mid);
    @(negedge clock);
    bus.send        = 1'b1;
    bus.data_in     = d;
    bus.parity_type = p;
    bus.baud_rate   = b;
    @(posedge clock);
    run_frame(d, p, b, mid, 1'b0, d);
    @(negedge clock);
    chk("post_idle_active", 32'(bus.active_flag), 32'd0);
    chk("post_idle_done", 32'(bus.done_flag), 32'd0);
    chk("post_idle_line", 32'(bus.data_tx), 32'd1);
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rp, rb;

    reset_n         = 1'b0;
    bus.send        = 1'b0;
    bus.data_in     = '0;
    bus.parity_type = '0;
    bus.baud_rate   = '0;
    repeat (3) @(negedge clock);
    chk("rst_line", 32'(bus.data_tx), 32'd1);
    chk("rst_active", 32'(bus.active_flag), 32'd0);
    chk("rst_done", 32'(bus.done_flag), 32'd0);
    reset_n = 1'b1;

    // Idle after reset with no request.
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      chk("idle_line", 32'(bus.data_tx), 32'd1);
      chk("idle_active", 32'(bus.active_flag), 32'd0);
      chk("idle_done", 32'(bus.done_flag), 32'd0);
    end

    // Reference frames.
    send_one(8'hA5, 2'b10, 2'b10, 1'b0);
    send_one(8'h00, 2'b01, 2'b11, 1'b0);
    send_one(8'h00, 2'b00, 2'b11, 1'b0);
    send_one(8'h00, 2'b11, 2'b11, 1'b0);

    // send held high: two frames, the second accepted in the done cycle.
    @(negedge clock);
    bus.send        = 1'b1;
    bus.data_in     = 8'h3C;
    bus.parity_type = 2'b01;
    bus.baud_rate   = 2'b00;
    @(posedge clock);
    run_frame(8'h3C, 2'b01, 2'b00, 1'b0, 1'b1, 8'hC3);
    prev_done = done_cyc;
    @(posedge clock);
    run_frame(8'hC3, 2'b01, 2'b00, 1'b0, 1'b0, 8'hC3);
    chk("b2b_spacing", 32'(done_cyc - prev_done), 32'(11 * ref_div(2'b00) + 1));
    @(negedge clock);
    chk("b2b_stop_active", 32'(bus.active_flag), 32'd0);

    // Mid-frame input changes are ignored and not queued.
    send_one(8'h5A, 2'b10, 2'b10, 1'b1);
    repeat (20) begin
      @(negedge clock);
      chk("mid_no_requeue", 32'(bus.active_flag | bus.done_flag), 32'd0);
    end

    // Reset during data bit 3 (frame bit 4, clocks 40..49 at DIV=10).
    @(negedge clock);
    bus.send        = 1'b1;
    bus.data_in     = 8'h00;
    bus.parity_type = 2'b10;
    bus.baud_rate   = 2'b10;
    @(posedge clock);
    @(negedge clock);
    bus.send = 1'b0;
    repeat (44) @(negedge clock);
    chk("pre_rst_line", 32'(bus.data_tx), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_line", 32'(bus.data_tx), 32'd1);
    chk("async_rst_active", 32'(bus.active_flag), 32'd0);
    repeat (5) begin
      @(negedge clock);
      chk("rst_no_done", 32'(bus.done_flag), 32'd0);
    end
    reset_n = 1'b1;
    repeat (150) begin
      @(negedge clock);
      chk("after_rst_idle", 32'(bus.done_flag | bus.active_flag), 32'd0);
    end
    send_one(8'h96, 2'b01, 2'b10, 1'b0);

    // Randomised frames against the model.
    for (int n = 0; n < 12; n++) begin
      rd = 8'($urandom);
      rp = 2'($urandom);
      rb = 2'($urandom_range(3, 1));
      send_one(rd, rp, rb, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
